// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus widths, FSM state
// encodings and the set of legal byte-lane enable patterns.
package dmem_responder_pkg;

  localparam int XLEN      = 32;
  localparam int ADDR_SIZE = 32;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmemState_t;

  localparam logic [3:0] AMP_NONE  = 4'b0000;
  localparam logic [3:0] AMP_BYTE0 = 4'b0001;
  localparam logic [3:0] AMP_BYTE1 = 4'b0010;
  localparam logic [3:0] AMP_BYTE2 = 4'b0100;
  localparam logic [3:0] AMP_BYTE3 = 4'b1000;
  localparam logic [3:0] AMP_HALF0 = 4'b0011;
  localparam logic [3:0] AMP_HALF1 = 4'b1100;
  localparam logic [3:0] AMP_WORD  = 4'b1111;

  // AMP_NONE is accepted here; rejecting it for stores is the caller's job.
  function automatic logic isLegalAmp(input logic [3:0] amp);
    case (amp)
      AMP_NONE, AMP_BYTE0, AMP_BYTE1, AMP_BYTE2, AMP_BYTE3,
      AMP_HALF0, AMP_HALF1, AMP_WORD: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational byte-lane merge: overlays the enabled lanes of writedata onto
// the stored word and flags whether the lane pattern is a legal access size.
module dmem_lane_merge
  import dmem_responder_pkg::*;
(
  input  logic [XLEN-1:0] oldWord,
  input  logic [XLEN-1:0] writedata,
  input  logic [3:0]      amp,
  output logic [XLEN-1:0] mergedWord,
  output logic            ampLegal
);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (amp[i]) mergedWord[8*i +: 8] = writedata[8*i +: 8];
    end
  end

  assign ampLegal = isLegalAmp(amp);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states,
// one-cycle ready pulse. Define DMEM_TRACE_EN to print store/error traces.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int                   DEPTH       = 1024,
  parameter int                   WAIT_CYCLES = 0,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 memwrite,
  input  logic [3:0]           amp,
  input  logic [ADDR_SIZE-1:0] daddr,
  input  logic [XLEN-1:0]      writedata,
  input  logic [ADDR_SIZE-1:0] pcM,
  output logic [XLEN-1:0]      readdata,
  output logic                 ready,
  output logic                 err
);

  localparam int                 IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_SIZE:0] LIMIT = (ADDR_SIZE+1)'(longint'(DEPTH) * 4);

  dmemState_t state, nextState;

  logic                 memwriteQ;
  logic [3:0]           ampQ;
  logic [ADDR_SIZE-1:0] daddrQ, pcQ;
  logic [XLEN-1:0]      writedataQ;
  logic [3:0]           waitCnt;
  logic [XLEN-1:0]      mem [DEPTH];

  logic                 selWrite, ampLegal, selErr;
  logic [3:0]           selAmp;
  logic [ADDR_SIZE-1:0] selAddr, off;
  logic [XLEN-1:0]      selWdata, oldWord, mergedWord;
  logic [IDX_W-1:0]     idx;

  // In IDLE the live bus is used so a zero-wait request can be resolved on
  // its accepting edge; afterwards the latched copy drives the datapath.
  assign selWrite = (state == DMEM_IDLE) ? memwrite  : memwriteQ;
  assign selAmp   = (state == DMEM_IDLE) ? amp       : ampQ;
  assign selAddr  = (state == DMEM_IDLE) ? daddr     : daddrQ;
  assign selWdata = (state == DMEM_IDLE) ? writedata : writedataQ;

  assign off     = selAddr - BASE_ADDR;
  assign idx     = off[IDX_W+1:2];
  assign oldWord = mem[idx];
  assign selErr  = (selAddr < BASE_ADDR) || ({1'b0, off} >= LIMIT) ||
                   !ampLegal || (selWrite && (selAmp == AMP_NONE));

  dmem_lane_merge u_merge (
    .oldWord   (oldWord),
    .writedata (selWdata),
    .amp       (selAmp),
    .mergedWord(mergedWord),
    .ampLegal  (ampLegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DMEM_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    ready     = 1'b0;
    case (state)
      DMEM_IDLE: if (req) nextState = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
      DMEM_WAIT: if (waitCnt == 4'd0) nextState = DMEM_RESP;
      DMEM_RESP: begin
        ready     = 1'b1;
        nextState = DMEM_IDLE;
      end
      default:   nextState = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwriteQ  <= 1'b0;
      ampQ       <= 4'b0;
      daddrQ     <= '0;
      writedataQ <= '0;
      pcQ        <= '0;
      waitCnt    <= 4'd0;
      readdata   <= '0;
      err        <= 1'b0;
    end else begin
      if (state == DMEM_IDLE && req) begin
        memwriteQ  <= memwrite;
        ampQ       <= amp;
        daddrQ     <= daddr;
        writedataQ <= writedata;
        pcQ        <= pcM;
        waitCnt    <= 4'(WAIT_CYCLES - 1);
      end else if (state == DMEM_WAIT && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end
      // Response is captured on the edge entering RESP, so readdata shows
      // the pre-write word while RESP is active.
      if (nextState == DMEM_RESP) begin
        err      <= selErr;
        readdata <= selErr ? '0 : oldWord;
      end
    end
  end

  // NOTE: the storage array has no reset; only the control path is cleared,
  // and a reset forces IDLE so an abandoned store never commits.
  always_ff @(posedge clk) begin
    if (state == DMEM_RESP && memwriteQ && !err) mem[idx] <= mergedWord;
  end

`ifdef DMEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (state == DMEM_RESP) begin
      if (err)
        $display("dmem err pc = %h addr = %h", pcQ, daddrQ);
      else if (memwriteQ)
        $display("pc = %h: dataaddr = %h, memdata = %h", pcQ, daddrQ, mergedWord);
    end
  end
`else
  logic unusedPc;
  assign unusedPc = ^pcQ;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (0 and 3 wait states)
// checked against an array-based reference model of the memory.
module tb_dmem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          W0    = 0;
  localparam int          W1    = 3;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    bit          chkRd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        memwrite = 1'b0;
  logic [3:0]  amp = 4'b0;
  logic [31:0] daddr = '0, writedata = '0, pcM = '0;
  logic [31:0] readdata0, readdata1;
  logic        ready0, ready1, err0, err1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q0[$], q1[$];
  logic [31:0] mdl [2][DEPTH];
  logic [3:0]  legalList [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .memwrite(memwrite), .amp(amp),
    .daddr(daddr), .writedata(writedata), .pcM(pcM),
    .readdata(readdata0), .ready(ready0), .err(err0)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .memwrite(memwrite), .amp(amp),
    .daddr(daddr), .writedata(writedata), .pcM(pcM),
    .readdata(readdata1), .ready(ready1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory with range and lane-pattern rules.
  function automatic void refModel(input int d, input bit wr, input logic [3:0] a,
                                   input logic [31:0] ad, input logic [31:0] wd,
                                   output bit e, output logic [31:0] rd);
    longint off;
    bit     legal;
    int     w;
    off   = longint'(ad) - longint'(BASE);
    legal = (a == 4'h1 || a == 4'h2 || a == 4'h4 || a == 4'h8 ||
             a == 4'h3 || a == 4'hC || a == 4'hF) || (a == 4'h0 && !wr);
    e  = (off < 0) || (off >= DEPTH * 4) || !legal;
    rd = 32'h0;
    if (!e) begin
      w  = int'(off / 4);
      rd = mdl[d][w];
      if (wr)
        for (int i = 0; i < 4; i++)
          if (a[i]) mdl[d][w][8*i +: 8] = wd[8*i +: 8];
    end
  endfunction

  task automatic doReq(input int d, input bit wr, input logic [3:0] a,
                       input logic [31:0] ad, input logic [31:0] wd, input bit chkRd);
    exp_t        e;
    bit          er;
    logic [31:0] rd;
    bit          seen;
    @(negedge clk);
    memwrite  = wr;
    amp       = a;
    daddr     = ad;
    writedata = wd;
    pcM       = $urandom;
    refModel(d, wr, a, ad, wd, er, rd);
    e.err   = er;
    e.rd    = rd;
    e.chkRd = chkRd;
    e.cyc   = cyc + 1 + ((d == 0) ? W0 : W1);
    if (d == 0) begin q0.push_back(e); req0 = 1'b1; end
    else        begin q1.push_back(e); req1 = 1'b1; end
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = (d == 0) ? ready0 : ready1;
    end
    check($sformatf("d%0d ready seen", d), {31'b0, seen}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic scoreResp(input int d, input exp_t e, input logic er, input logic [31:0] rd);
    check($sformatf("d%0d err", d), {31'b0, er}, {31'b0, e.err});
    if (e.chkRd) check($sformatf("d%0d readdata", d), rd, e.rd);
    check($sformatf("d%0d ready cycle", d), 32'(cyc), 32'(e.cyc));
  endtask

  // Monitors: pop one expectation per ready pulse, then confirm readdata holds.
  logic [31:0] last0, last1;
  bit          hold0 = 1'b0, hold1 = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ready0) begin
        if (q0.size() == 0) check("d0 unexpected ready", 32'd1, 32'd0);
        else scoreResp(0, q0.pop_front(), err0, readdata0);
        last0 = readdata0;
        hold0 = 1'b1;
      end else if (hold0) begin
        check("d0 readdata hold", readdata0, last0);
        hold0 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ready1) begin
        if (q1.size() == 0) check("d1 unexpected ready", 32'd1, 32'd0);
        else scoreResp(1, q1.pop_front(), err1, readdata1);
        last1 = readdata1;
        hold1 = 1'b1;
      end else if (hold1) begin
        check("d1 readdata hold", readdata1, last1);
        hold1 = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr;
    logic [3:0]  a;
    logic [31:0] ad;

    repeat (3) @(negedge clk);
    check("reset ready0", {31'b0, ready0}, 32'd0);
    check("reset err0", {31'b0, err0}, 32'd0);
    check("reset readdata0", readdata0, 32'd0);
    check("reset ready1", {31'b0, ready1}, 32'd0);
    check("reset readdata1", readdata1, 32'd0);
    reset = 1'b0;

    // Give every word a known value; the pre-write readdata is unknown here.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        doReq(d, 1'b1, 4'hF, BASE + 32'(i * 4), $urandom, 1'b0);

    // Directed cases on the zero-wait instance.
    doReq(0, 1'b1, 4'b1111, BASE + 32'h10, 32'hDEADBEEF, 1'b1);
    doReq(0, 1'b0, 4'b1111, BASE + 32'h10, 32'h0, 1'b1);
    doReq(0, 1'b1, 4'b1111, BASE + 32'h20, 32'h11223344, 1'b1);
    doReq(0, 1'b1, 4'b0100, BASE + 32'h20, 32'h00AA0000, 1'b1);
    doReq(0, 1'b1, 4'b0011, BASE + 32'h20, 32'h0000BBCC, 1'b1);
    doReq(0, 1'b0, 4'b0000, BASE + 32'h22, 32'h0, 1'b1);
    doReq(0, 1'b1, 4'b0110, BASE + 32'h20, 32'hFFFFFFFF, 1'b1);
    doReq(0, 1'b0, 4'b1111, BASE + 32'(DEPTH * 4), 32'h0, 1'b1);
    doReq(0, 1'b1, 4'b0000, BASE + 32'h20, 32'hFFFFFFFF, 1'b1);
    doReq(0, 1'b0, 4'b1111, BASE - 32'd4, 32'h0, 1'b1);
    doReq(0, 1'b0, 4'b1111, 32'hFFFF_FFFC, 32'h0, 1'b1);
    doReq(0, 1'b0, 4'b1111, BASE + 32'h20, 32'h0, 1'b1);
    doReq(0, 1'b1, 4'b1111, BASE + 32'h30, 32'hAAAAAAAA, 1'b1);
    doReq(0, 1'b1, 4'b0001, BASE + 32'h30, 32'h00000055, 1'b1);
    doReq(0, 1'b0, 4'b1111, BASE + 32'h30, 32'h0, 1'b1);
    doReq(0, 1'b1, 4'b1111, BASE + 32'(DEPTH * 4 - 4), 32'h0BADF00D, 1'b1);
    doReq(0, 1'b0, 4'b1111, BASE + 32'(DEPTH * 4 - 4), 32'h0, 1'b1);

    // Wait-state instance: a few directed accesses.
    doReq(1, 1'b1, 4'b1111, BASE + 32'h08, 32'h12345678, 1'b1);
    doReq(1, 1'b0, 4'b1111, BASE + 32'h08, 32'h0, 1'b1);
    doReq(1, 1'b1, 4'b1100, BASE + 32'h08, 32'hABCD0000, 1'b1);
    doReq(1, 1'b0, 4'b1111, BASE + 32'(DEPTH * 4), 32'h0, 1'b1);

    // Reset in the middle of a store's wait states.
    doReq(1, 1'b0, 4'b1111, BASE + 32'h08, 32'h0, 1'b1);
    @(negedge clk);
    memwrite  = 1'b1;
    amp       = 4'hF;
    daddr     = BASE + 32'h08;
    writedata = 32'hCAFEF00D;
    req1      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid-wait reset ready1", {31'b0, ready1}, 32'd0);
    check("mid-wait reset err1", {31'b0, err1}, 32'd0);
    check("mid-wait reset readdata1", readdata1, 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    doReq(1, 1'b0, 4'b1111, BASE + 32'h08, 32'h0, 1'b1);

    // Randomized traffic on both instances.
    for (int n = 0; n < 240; n++) begin
      wr = 1'($urandom % 2);
      if ($urandom % 8 == 0) a = 4'($urandom);
      else                   a = legalList[$urandom % 7];
      if ($urandom % 16 == 0) ad = $urandom;
      else                    ad = BASE - 32'd8 + 32'($urandom_range(0, 79));
      doReq(n % 2, wr, a, ad, $urandom, 1'b1);
    end

    repeat (4) @(negedge clk);
    check("d0 leftover expectations", 32'(q0.size()), 32'd0);
    check("d1 leftover expectations", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
